// File: rtl/nibbler_sequencer.sv
// Nibbler CPU sequencer: owns the PC, runs FETCH/EXECUTE over the 8-bit ROM,
// resolves conditional jumps from the {C,Z} flags and strobes decoded ops.
module nibbler_sequencer #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [7:0]        rom_data,
  input  logic [1:0]        flags,
  output logic [ADDR_W-1:0] pc_out,
  output logic              phase,
  output logic              op_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        imm,
  output logic [11:0]       operand_addr,
  output logic              jump_taken,
  output logic              halted,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  // Handshake: none. The ROM is combinational and answers for pc_out in the
  // same cycle; stall=1 freezes everything and suppresses both strobes.

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [7:0]        ir, irNext;
  logic [3:0]        opcodeQ, opcodeNext;
  logic [3:0]        immQ, immNext;
  logic [11:0]       operandQ, operandNext;
  logic              opValidQ, opValidNext;
  logic              jumpQ, jumpNext;
  logic              haltedQ, haltedNext;
  logic              isBranch, isTaken;

  always_comb begin
    isBranch = 1'b1;
    isTaken  = 1'b0;
    unique case (ir[7:4])
      4'h0: isTaken = flags[1];
      4'h1: isTaken = ~flags[1];
      4'h2: isTaken = flags[0];
      4'h3: isTaken = ~flags[0];
      4'hA: isTaken = 1'b1;
      default: isBranch = 1'b0;
    endcase
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    irNext      = ir;
    opcodeNext  = opcodeQ;
    immNext     = immQ;
    operandNext = operandQ;
    opValidNext = 1'b0;
    jumpNext    = 1'b0;
    haltedNext  = haltedQ;
    if (!stall) begin
      unique case (state)
        FETCH: begin
          irNext    = rom_data;
          pcNext    = pc + ADDR_W'(1);
          stateNext = EXECUTE;
        end
        EXECUTE: begin
          // rom_data now carries byte1 of the instruction latched in ir.
          opcodeNext  = ir[7:4];
          immNext     = ir[3:0];
          operandNext = {ir[3:0], rom_data};
          pcNext      = pc + ADDR_W'(1);
          stateNext   = FETCH;
          if (ir[7:4] == 4'hF) begin
            stateNext  = HALTED;
            haltedNext = 1'b1;
          end else if (isBranch) begin
            if (isTaken) begin
              pcNext   = ADDR_W'({ir[3:0], rom_data});
              jumpNext = 1'b1;
            end
          end else begin
            opValidNext = 1'b1;
          end
        end
        default: begin
          stateNext = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= 8'h00;
      opcodeQ  <= 4'h0;
      immQ     <= 4'h0;
      operandQ <= 12'h000;
      opValidQ <= 1'b0;
      jumpQ    <= 1'b0;
      haltedQ  <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      ir       <= irNext;
      opcodeQ  <= opcodeNext;
      immQ     <= immNext;
      operandQ <= operandNext;
      opValidQ <= opValidNext;
      jumpQ    <= jumpNext;
      haltedQ  <= haltedNext;
    end
  end

  assign pc_out       = pc;
  assign phase        = (state == EXECUTE);
  assign op_valid     = opValidQ;
  assign opcode       = opcodeQ;
  assign imm          = immQ;
  assign operand_addr = operandQ;
  assign jump_taken   = jumpQ;
  assign halted       = haltedQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer: instruction-level reference model checked every
// cycle, a strobe scoreboard, and hand-computed checkpoints from directed programs.
module tb_nibbler_sequencer;

  localparam int unsigned ADDR_W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [1:0]        flags = 2'b00;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] pc_out;
  logic              phase, op_valid, jump_taken, halted;
  logic [3:0]        opcode, imm;
  logic [11:0]       operand_addr;
  logic [1:0]        dbgState;

  logic [7:0] rom [4096];
  assign rom_data = rom[pc_out];

  nibbler_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .rom_data(rom_data), .flags(flags),
    .pc_out(pc_out), .phase(phase), .op_valid(op_valid), .opcode(opcode),
    .imm(imm), .operand_addr(operand_addr), .jump_taken(jump_taken),
    .halted(halted), .dbgState(dbgState)
  );

  int nChecks = 0;
  int nFails  = 0;
  bit live    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction-level view: a PC, a "mid-instruction" flag with the first byte
  // captured, the last completed instruction's fields, and the strobe events.
  logic [11:0] mPc;
  logic        mMid, mHalt, mOv, mJt;
  logic [7:0]  mByte0;
  logic [3:0]  mOp, mImm;
  logic [11:0] mOpd;
  logic [16:0] exp_q[$];

  function automatic logic [1:0] decodeBranch(input logic [3:0] op, input logic [1:0] f);
    // returns {is_branch, taken}; f = {C, Z}
    case (op)
      4'h0: return {1'b1, f[1] == 1'b1};
      4'h1: return {1'b1, f[1] == 1'b0};
      4'h2: return {1'b1, f[0] == 1'b1};
      4'h3: return {1'b1, f[0] == 1'b0};
      4'hA: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0]  b1;
    logic [1:0]  br;
    logic [11:0] target;
    mOv = 1'b0;
    mJt = 1'b0;
    if (reset) begin
      mPc = 12'h000; mMid = 1'b0; mHalt = 1'b0; mByte0 = 8'h00;
      mOp = 4'h0; mImm = 4'h0; mOpd = 12'h000;
      exp_q.delete();
    end else if (!stall && !mHalt) begin
      if (!mMid) begin
        mByte0 = rom[mPc];
        mPc    = mPc + 12'd1;
        mMid   = 1'b1;
      end else begin
        b1     = rom[mPc];
        target = {mByte0[3:0], b1};
        mOp    = mByte0[7:4];
        mImm   = mByte0[3:0];
        mOpd   = target;
        mMid   = 1'b0;
        br     = decodeBranch(mByte0[7:4], flags);
        if (mByte0[7:4] == 4'hF) begin
          mHalt = 1'b1;
          mPc   = mPc + 12'd1;
        end else if (br[1] && br[0]) begin
          mPc = target;
          mJt = 1'b1;
          exp_q.push_back({1'b1, mOp, mOpd});
        end else begin
          mPc = mPc + 12'd1;
          if (!br[1]) begin
            mOv = 1'b1;
            exp_q.push_back({1'b0, mOp, mOpd});
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] got;
    if (live) begin
      check("pc_out", 32'(pc_out), 32'(mPc));
      check("phase", 32'(phase), 32'(mMid));
      check("halted", 32'(halted), 32'(mHalt));
      check("op_valid", 32'(op_valid), 32'(mOv));
      check("jump_taken", 32'(jump_taken), 32'(mJt));
      check("opcode", 32'(opcode), 32'(mOp));
      check("imm", 32'(imm), 32'(mImm));
      check("operand_addr", 32'(operand_addr), 32'(mOpd));
      if (op_valid || jump_taken) begin
        got = {jump_taken, opcode, operand_addr};
        if (exp_q.size() == 0) check("strobe_unexpected", 32'(got), 32'h1ffff);
        else check("strobe_event", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clearRom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h40;  // 0x4x: plain non-branch op
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    live  = 1'b1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clearRom();
    doReset();
    check("rst_pc", 32'(pc_out), 32'h000);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);

    // Straight-line non-branch
    rom[0] = 8'h5B; rom[1] = 8'h3C;
    runCycles(2);
    check("sl_op_valid", 32'(op_valid), 32'h1);
    check("sl_opcode", 32'(opcode), 32'h5);
    check("sl_imm", 32'(imm), 32'hB);
    check("sl_operand", 32'(operand_addr), 32'hB3C);
    check("sl_pc", 32'(pc_out), 32'h002);
    check("sl_phase", 32'(phase), 32'h0);
    runCycles(1);
    check("sl_strobe_one_cycle", 32'(op_valid), 32'h0);

    // JC 0x123, carry set then clear
    clearRom();
    rom[0] = 8'h01; rom[1] = 8'h23;
    flags = 2'b10;
    doReset();
    runCycles(2);
    check("jc_taken", 32'(jump_taken), 32'h1);
    check("jc_pc", 32'(pc_out), 32'h123);
    flags = 2'b00;
    doReset();
    runCycles(2);
    check("jc_nt_jump", 32'(jump_taken), 32'h0);
    check("jc_nt_opv", 32'(op_valid), 32'h0);
    check("jc_nt_pc", 32'(pc_out), 32'h002);

    // JNZ 0x045
    rom[0] = 8'h30; rom[1] = 8'h45;
    flags = 2'b00;
    doReset();
    runCycles(2);
    check("jnz_taken_pc", 32'(pc_out), 32'h045);
    flags = 2'b01;
    doReset();
    runCycles(2);
    check("jnz_nt_pc", 32'(pc_out), 32'h002);
    check("jnz_nt_jump", 32'(jump_taken), 32'h0);

    // JMP from the top of memory wraps the PC
    clearRom();
    rom[0] = 8'hAF; rom[1] = 8'hFE;
    rom[12'hFFE] = 8'hA0; rom[12'hFFF] = 8'h05;
    doReset();
    runCycles(2);
    check("jmp_to_ffe", 32'(pc_out), 32'hFFE);
    runCycles(2);
    check("jmp_wrap_pc", 32'(pc_out), 32'h005);
    check("jmp_wrap_jt", 32'(jump_taken), 32'h1);
    rom[12'hFFE] = 8'h50; rom[12'hFFF] = 8'h11;
    doReset();
    runCycles(4);
    check("nb_wrap_pc", 32'(pc_out), 32'h000);
    check("nb_wrap_opd", 32'(operand_addr), 32'h011);
    check("nb_wrap_opv", 32'(op_valid), 32'h1);

    // HLT freezes everything until reset
    clearRom();
    rom[0] = 8'hF0;
    doReset();
    runCycles(2);
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_pc", 32'(pc_out), 32'h002);
    for (int i = 0; i < 20; i++) begin
      flags = 2'(i);
      runCycles(1);
      check("hlt_frozen_pc", 32'(pc_out), 32'h002);
      check("hlt_no_strobe", 32'({op_valid, jump_taken}), 32'h0);
    end
    doReset();
    check("hlt_rst_pc", 32'(pc_out), 32'h000);
    check("hlt_rst_halted", 32'(halted), 32'h0);
    check("hlt_rst_phase", 32'(phase), 32'h0);

    // Stall in EXECUTE of JZ 0x077 while Z drops; released with Z=0
    clearRom();
    rom[0] = 8'h20; rom[1] = 8'h77;
    flags = 2'b01;
    doReset();
    runCycles(1);
    check("st_in_exec", 32'(phase), 32'h1);
    stall = 1'b1;
    runCycles(1);
    flags = 2'b00;
    runCycles(2);
    check("st_hold_pc", 32'(pc_out), 32'h001);
    check("st_hold_phase", 32'(phase), 32'h1);
    stall = 1'b0;
    runCycles(1);
    check("st_rel_pc", 32'(pc_out), 32'h002);
    check("st_rel_jump", 32'(jump_taken), 32'h0);

    // Reset wins over stall mid-EXECUTE
    rom[0] = 8'h5B; rom[1] = 8'h3C;
    doReset();
    runCycles(1);
    reset = 1'b1; stall = 1'b1;
    runCycles(1);
    check("rp_pc", 32'(pc_out), 32'h000);
    check("rp_phase", 32'(phase), 32'h0);
    check("rp_opv", 32'(op_valid), 32'h0);
    reset = 1'b0; stall = 1'b0;

    // Short mixed program with changing flags, checked by the model
    clearRom();
    rom[0] = 8'h61; rom[1] = 8'h11;   // non-branch
    rom[2] = 8'h20; rom[3] = 8'h08;   // JZ 0x008
    rom[4] = 8'h70; rom[5] = 8'h22;   // non-branch
    rom[6] = 8'hA0; rom[7] = 8'h00;   // JMP 0x000
    rom[8] = 8'h10; rom[9] = 8'h04;   // JNC 0x004
    doReset();
    for (int i = 0; i < 40; i++) begin
      flags = 2'(i / 3);
      if (i % 7 == 5) stall = 1'b1;
      runCycles(1);
      stall = 1'b0;
    end
    runCycles(2);
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
